// File: rtl/whack_pkg.sv
// Shared types and helpers for the whack-a-mole game controller.
// Latency: none (types and pure functions only).
// Backpressure: none.
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    PLAYING = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam int SCORE_W_DEF = 8;

  // Number of set bits in a zero-extended strobe vector.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  // a + b clamped to maxv; computed one bit wider so the sum cannot wrap.
  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned maxv);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, maxv}) return maxv;
    return s[31:0];
  endfunction

endpackage

// File: rtl/whack_game_ctrl_if.sv
// Signal bundle between the game controller and its surroundings (buttons, moles, timer, display).
// Latency: none (wires only).
// Backpressure: none; all signals are levels or single-cycle strobes.
interface whack_game_ctrl_if #(
  parameter int NUM_MOLES = 4,
  parameter int SCORE_W   = 8,
  parameter int TS_W      = 5
);
  logic                 start;
  logic [NUM_MOLES-1:0] hit_pulse;
  logic [NUM_MOLES-1:0] mole_up;
  logic [TS_W-1:0]      timer_seconds;
  logic                 timer_rst;
  logic                 timer_enable;
  logic                 playing;
  logic                 game_over;
  logic [SCORE_W-1:0]   score;
  logic [SCORE_W-1:0]   misses;
  logic [SCORE_W-1:0]   high_score;
  logic                 new_record;

  // Controller side.
  modport master (
    input  start, hit_pulse, mole_up, timer_seconds,
    output timer_rst, timer_enable, playing, game_over,
           score, misses, high_score, new_record
  );

  // Environment side.
  modport slave (
    output start, hit_pulse, mole_up, timer_seconds,
    input  timer_rst, timer_enable, playing, game_over,
           score, misses, high_score, new_record
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating accumulator: adds a small increment each enabled cycle, clamps at all-ones.
// Latency: 1 cycle from en/add/clr to cnt.
// Backpressure: none; clr has priority over en.
module sat_counter
  import whack_pkg::*;
#(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [AW-1:0] add,
  output logic [W-1:0]  cnt
);

  localparam int unsigned MAXV = 32'((64'd1 << W) - 64'd1);

  // Clear wins; otherwise accumulate and stick at the maximum instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= W'(sat_add(32'(cnt), 32'(add), MAXV));
    end
  end

endmodule

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole round controller: sequences IDLE/ARM/PLAYING/OVER, scores hits, keeps the high score.
// Latency: state-decoded outputs follow the state register; score/misses/high_score/new_record 1 cycle after inputs.
// Backpressure: none; start is ignored while playing, hit strobes outside PLAYING are dropped.
module whack_game_ctrl
  import whack_pkg::*;
#(
  parameter int GAME_LENGTH_SECONDS = 20,
  parameter int CLKS_PER_MS         = 50000,
  parameter int HOLD_MS             = 3000,
  parameter int NUM_MOLES           = 4,
  parameter int SCORE_W             = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  whack_game_ctrl_if.master  bus
);

  localparam int AW   = $clog2(NUM_MOLES + 1);
  localparam int PS_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int MS_W = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_MS - 1);
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(HOLD_MS - 1);
  localparam int unsigned SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

  state_t             state_q, state_d;
  logic               armed_q;
  logic [PS_W-1:0]    ps_q;
  logic [MS_W-1:0]    ms_q;
  logic [SCORE_W-1:0] high_q;
  logic               rec_q;
  logic [SCORE_W-1:0] score_q, miss_q, score_fin;
  logic [AW-1:0]      hits, empties;
  logic               time_up, hold_done;
  logic               t_rst, t_en, ply, ovr;

  assign hits    = AW'(popcount(32'(bus.hit_pulse & bus.mole_up)));
  assign empties = AW'(popcount(32'(bus.hit_pulse & ~bus.mole_up)));

  // The timer idles at 0 before it is loaded, so time-up only counts after a non-zero reading.
  assign time_up   = (state_q == PLAYING) && armed_q && (bus.timer_seconds == '0);
  assign hold_done = (ps_q == PS_LAST) && (ms_q == MS_LAST);

  // Final score including any hits landing on the time-up cycle.
  assign score_fin = SCORE_W'(sat_add(32'(score_q), 32'(hits), SCORE_MAX));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and state-decoded outputs; timer_rst is a pure decode, so it is high in IDLE even under reset.
  always_comb begin
    state_d = state_q;
    t_rst   = 1'b0;
    t_en    = 1'b0;
    ply     = 1'b0;
    ovr     = 1'b0;
    case (state_q)
      IDLE: begin
        t_rst = 1'b1;
        if (bus.start) state_d = ARM;
      end
      ARM: begin
        t_rst   = 1'b1;
        state_d = PLAYING;
      end
      PLAYING: begin
        t_en = 1'b1;
        ply  = 1'b1;
        if (time_up) state_d = OVER;
      end
      OVER: begin
        ovr = 1'b1;
        if (bus.start)     state_d = ARM;
        else if (hold_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Armed flag: dropped while arming, set by the first non-zero timer reading in play.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else if (state_q == ARM) begin
      armed_q <= 1'b0;
    end else if ((state_q == PLAYING) && (bus.timer_seconds != '0)) begin
      armed_q <= 1'b1;
    end
  end

  // Game-over hold timer: ms prescaler feeding a ms count, parked at zero outside OVER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q <= '0;
      ms_q <= '0;
    end else if (state_q != OVER) begin
      ps_q <= '0;
      ms_q <= '0;
    end else if (ps_q == PS_LAST) begin
      ps_q <= '0;
      if (ms_q != MS_LAST) ms_q <= ms_q + MS_W'(1);
    end else begin
      ps_q <= ps_q + PS_W'(1);
    end
  end

  // High score captured on the time-up cycle; strict improvement only, with a one-cycle record flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_q <= '0;
      rec_q  <= 1'b0;
    end else begin
      rec_q <= 1'b0;
      if (time_up && (score_fin > high_q)) begin
        high_q <= score_fin;
        rec_q  <= 1'b1;
      end
    end
  end

  sat_counter #(.W(SCORE_W), .AW(AW)) u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == ARM),
    .en    (state_q == PLAYING),
    .add   (hits),
    .cnt   (score_q)
  );

  sat_counter #(.W(SCORE_W), .AW(AW)) u_misses (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == ARM),
    .en    (state_q == PLAYING),
    .add   (empties),
    .cnt   (miss_q)
  );

  assign bus.timer_rst    = t_rst;
  assign bus.timer_enable = t_en;
  assign bus.playing      = ply;
  assign bus.game_over    = ovr;
  assign bus.score        = score_q;
  assign bus.misses       = miss_q;
  assign bus.high_score   = high_q;
  assign bus.new_record   = rec_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Bench for whack_game_ctrl: directed vector table, async reset sequence, randomized run against a model.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: none.
module tb_whack_game_ctrl;

  localparam int NM   = 4;
  localparam int SW   = 3;
  localparam int CPM  = 2;
  localparam int HMS  = 3;
  localparam int GL   = 20;
  localparam int TSW  = $clog2(GL);
  localparam int SMAX = (1 << SW) - 1;

  // Expected {timer_rst, timer_enable, playing, game_over} per phase.
  localparam logic [3:0] PH_IDLE = 4'b1000;
  localparam logic [3:0] PH_ARM  = 4'b1000;
  localparam logic [3:0] PH_PLAY = 4'b0110;
  localparam logic [3:0] PH_OVER = 4'b0001;

  typedef struct {
    logic           st;
    logic [NM-1:0]  hp;
    logic [NM-1:0]  mu;
    logic [TSW-1:0] ts;
    logic [13:0]    ex;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  whack_game_ctrl_if #(.NUM_MOLES(NM), .SCORE_W(SW), .TS_W(TSW)) bus ();

  whack_game_ctrl #(
    .GAME_LENGTH_SECONDS (GL),
    .CLKS_PER_MS         (CPM),
    .HOLD_MS             (HMS),
    .NUM_MOLES           (NM),
    .SCORE_W             (SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] pk(input logic [3:0] ph, input int sc, input int ms,
                                     input int hs, input logic nr);
    return {ph, 3'(sc), 3'(ms), 3'(hs), nr};
  endfunction

  function automatic vec_t v(input logic st, input logic [NM-1:0] hp, input logic [NM-1:0] mu,
                             input int ts, input logic [3:0] ph, input int sc, input int ms,
                             input int hs, input logic nr);
    vec_t r;
    r.st = st; r.hp = hp; r.mu = mu; r.ts = TSW'(ts);
    r.ex = pk(ph, sc, ms, hs, nr);
    return r;
  endfunction

  task automatic drive(input logic st, input logic [NM-1:0] hp, input logic [NM-1:0] mu,
                       input logic [TSW-1:0] ts);
    bus.start         = st;
    bus.hit_pulse     = hp;
    bus.mole_up       = mu;
    bus.timer_seconds = ts;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [13:0] ex);
    logic [13:0] ob;
    ob = {bus.timer_rst, bus.timer_enable, bus.playing, bus.game_over,
          bus.score, bus.misses, bus.high_score, bus.new_record};
    n_vec++;
    if (ob !== ex) begin
      n_bad++;
      $display("FAIL %s: got rst/en/ply/ovr=%b score=%0d misses=%0d high=%0d rec=%b, expected rst/en/ply/ovr=%b score=%0d misses=%0d high=%0d rec=%b",
               nm, ob[13:10], ob[9:7], ob[6:4], ob[3:1], ob[0],
               ex[13:10], ex[9:7], ex[6:4], ex[3:1], ex[0]);
    end
  endtask

  // Reference model: phase name, cycles spent in game-over, plain saturating integers.
  string m_ph;
  bit    m_armed;
  int    m_hold, m_sc, m_ms, m_hs;
  bit    m_nr;

  task automatic model_reset();
    m_ph = "idle"; m_armed = 0; m_hold = 0;
    m_sc = 0; m_ms = 0; m_hs = 0; m_nr = 0;
  endtask

  task automatic model_step(input logic st, input logic [NM-1:0] hp, input logic [NM-1:0] mu,
                            input logic [TSW-1:0] ts);
    int h, e;
    bit tu;
    h = $countones(hp & mu);
    e = $countones(hp & ~mu);
    m_nr = 0;
    if (m_ph == "idle") begin
      if (st) m_ph = "arm";
    end else if (m_ph == "arm") begin
      m_sc = 0; m_ms = 0; m_armed = 0;
      m_ph = "play";
    end else if (m_ph == "play") begin
      tu   = m_armed && (ts == 0);
      m_sc = (m_sc + h > SMAX) ? SMAX : m_sc + h;
      m_ms = (m_ms + e > SMAX) ? SMAX : m_ms + e;
      if (ts != 0) m_armed = 1;
      if (tu) begin
        m_ph = "over";
        m_hold = 0;
        if (m_sc > m_hs) begin
          m_hs = m_sc;
          m_nr = 1;
        end
      end
    end else begin
      if (st) m_ph = "arm";
      else if (m_hold == HMS * CPM - 1) m_ph = "idle";
      else m_hold++;
    end
  endtask

  function automatic logic [13:0] model_exp();
    logic [3:0] ph;
    if (m_ph == "play")      ph = PH_PLAY;
    else if (m_ph == "over") ph = PH_OVER;
    else                     ph = PH_IDLE;
    return pk(ph, m_sc, m_ms, m_hs, m_nr);
  endfunction

  initial begin
    logic          r_st;
    logic [NM-1:0] r_hp, r_mu;
    logic [TSW-1:0] r_ts;

    // Game 1: start, ARM for one cycle, scoring, time-up at 0 with new record 5.
    tbl.push_back(v(1, 4'b0000, 4'b0000, 0, PH_ARM,  0, 0, 0, 0));
    tbl.push_back(v(0, 4'b1111, 4'b1111, 3, PH_PLAY, 0, 0, 0, 0));
    tbl.push_back(v(0, 4'b0111, 4'b0101, 3, PH_PLAY, 2, 1, 0, 0));
    tbl.push_back(v(0, 4'b0001, 4'b1111, 3, PH_PLAY, 3, 1, 0, 0));
    tbl.push_back(v(0, 4'b0010, 4'b0010, 2, PH_PLAY, 4, 1, 0, 0));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 1, PH_PLAY, 4, 1, 0, 0));
    tbl.push_back(v(0, 4'b1000, 4'b1000, 0, PH_OVER, 5, 1, 5, 1));
    tbl.push_back(v(0, 4'b1111, 4'b1111, 0, PH_OVER, 5, 1, 5, 0));
    // Game 2: early restart, unarmed zero ignored, start ignored in play, tie on time-up hit.
    tbl.push_back(v(1, 4'b0000, 4'b0000, 0, PH_ARM,  5, 1, 5, 0));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, PH_PLAY, 0, 0, 5, 0));
    tbl.push_back(v(0, 4'b0011, 4'b0011, 0, PH_PLAY, 2, 0, 5, 0));
    tbl.push_back(v(1, 4'b0100, 4'b0100, 1, PH_PLAY, 3, 0, 5, 0));
    tbl.push_back(v(0, 4'b1000, 4'b0000, 1, PH_PLAY, 3, 1, 5, 0));
    tbl.push_back(v(0, 4'b0001, 4'b0001, 1, PH_PLAY, 4, 1, 5, 0));
    tbl.push_back(v(0, 4'b0010, 4'b0010, 0, PH_OVER, 5, 1, 5, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(v(0, 4'b0000, 4'b0000, 0, PH_OVER, 5, 1, 5, 0));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, PH_IDLE, 5, 1, 5, 0));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, PH_IDLE, 5, 1, 5, 0));
    // Game 3: zero score, start on the hold-expiry cycle goes to ARM.
    tbl.push_back(v(1, 4'b0000, 4'b0000, 0, PH_ARM,  5, 1, 5, 0));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 2, PH_PLAY, 0, 0, 5, 0));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 2, PH_PLAY, 0, 0, 5, 0));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, PH_OVER, 0, 0, 5, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(v(0, 4'b0000, 4'b0000, 0, PH_OVER, 0, 0, 5, 0));
    tbl.push_back(v(1, 4'b0000, 4'b0000, 0, PH_ARM,  0, 0, 5, 0));
    // Game 4: 9 hits and 8 misses saturate at 7; new record 7.
    tbl.push_back(v(0, 4'b0000, 4'b0000, 5, PH_PLAY, 0, 0, 5, 0));
    tbl.push_back(v(0, 4'b1111, 4'b1111, 5, PH_PLAY, 4, 0, 5, 0));
    tbl.push_back(v(0, 4'b1111, 4'b1111, 5, PH_PLAY, 7, 0, 5, 0));
    tbl.push_back(v(0, 4'b0001, 4'b0001, 5, PH_PLAY, 7, 0, 5, 0));
    tbl.push_back(v(0, 4'b1111, 4'b0000, 5, PH_PLAY, 7, 4, 5, 0));
    tbl.push_back(v(0, 4'b1111, 4'b0000, 5, PH_PLAY, 7, 7, 5, 0));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, PH_OVER, 7, 7, 7, 1));
    tbl.push_back(v(0, 4'b0000, 4'b0000, 0, PH_OVER, 7, 7, 7, 0));

    rst_n = 1'b0;
    drive(0, '0, '0, '0);
    step();
    step();
    chk("reset", pk(PH_IDLE, 0, 0, 0, 0));
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", pk(PH_IDLE, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].hp, tbl[i].mu, tbl[i].ts);
      step();
      chk($sformatf("vec%0d", i), tbl[i].ex);
    end

    // Asynchronous reset in the middle of a game.
    drive(1, '0, '0, '0);
    step();
    chk("mid_arm", pk(PH_ARM, 7, 7, 7, 0));
    drive(0, '0, '0, TSW'(3));
    step();
    drive(0, 4'b1111, 4'b1111, TSW'(3));
    step();
    chk("mid_play", pk(PH_PLAY, 4, 0, 7, 0));
    drive(0, '0, '0, TSW'(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", pk(PH_IDLE, 0, 0, 0, 0));
    step();
    rst_n = 1'b1;
    chk("held_reset", pk(PH_IDLE, 0, 0, 0, 0));

    // Randomized play against the model.
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      r_st = ($urandom_range(0, 7) == 0);
      r_hp = NM'($urandom & $urandom);
      r_mu = NM'($urandom);
      r_ts = TSW'($urandom_range(0, 3));
      drive(r_st, r_hp, r_mu, r_ts);
      model_step(r_st, r_hp, r_mu, r_ts);
      step();
      chk($sformatf("rand%0d", c), model_exp());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
